piece_sequencer: RTL

Owns the active falling tetromino type and a next-piece preview queue. Fetches pieces from the 7-bag generator over a valid/ready handshake and services lock-spawn and hold requests from the game FSM and the hold handler. Its outputs drive the spawn logic, the preview panel renderer, and the hold handler's new_tetromino and falling_type inputs.

---
 rtl/DisplayPkg.sv | 16 +
 rtl/piece_sequencer_if.sv | 32 +++
 rtl/piece_queue.sv | 58 +++++
 rtl/piece_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/DisplayPkg.sv
// Shared display/game types: tetromino tile codes plus the piece sequencer's
// state encoding and default preview depth.
package DisplayPkg;

  typedef enum logic [2:0] {
    BLANK = 3'd0, I = 3'd1, O = 3'd2, T = 3'd3, S = 3'd4, Z = 3'd5, J = 3'd6, L = 3'd7
  } tile_type_t;

  localparam int PREVIEW_DEPTH_DEFAULT = 3;

  typedef enum logic [1:0] {IDLE, FILL, READY, STALL} seq_state_t;

  // Which pulse a stalled fetch owes once the bag delivers.
  typedef enum logic {PEND_SPAWN, PEND_HOLD} pend_t;

endpackage

// File: rtl/piece_sequencer_if.sv
// Request, bag handshake and piece-output bundle between the game side and
// the piece sequencer.
interface piece_sequencer_if #(
  parameter int PREVIEW_DEPTH = DisplayPkg::PREVIEW_DEPTH_DEFAULT
);
  import DisplayPkg::*;

  logic       game_start;
  logic       spawn_req;
  logic       hold_req;
  logic       hold_swap;
  tile_type_t hold_type;
  logic       bag_valid;
  tile_type_t bag_type;
  logic       bag_ready;
  tile_type_t falling_type;
  logic       falling_valid;
  logic       new_tetromino;
  logic       hold_done;
  tile_type_t preview [PREVIEW_DEPTH];

  modport master (
    output game_start, spawn_req, hold_req, hold_swap, hold_type, bag_valid, bag_type,
    input  bag_ready, falling_type, falling_valid, new_tetromino, hold_done, preview
  );

  modport slave (
    input  game_start, spawn_req, hold_req, hold_swap, hold_type, bag_valid, bag_type,
    output bag_ready, falling_type, falling_valid, new_tetromino, hold_done, preview
  );

endinterface

// File: rtl/piece_queue.sv
// Shift FIFO: slot 0 is the head, pops shift toward it, empty slots read zero.
// Caller guarantees no push when full and no pop when empty.
module piece_queue #(
  parameter int  DEPTH = 3,
  parameter int  W     = 3,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [W-1:0]       push_data_i,
  input  logic               pop_i,
  output logic [CW-1:0]      count_o,
  output logic [DEPTH*W-1:0] slots_o
);

  logic [DEPTH-1:0][W-1:0] slots_q, slots_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           push_idx;

  // A simultaneous pop moves the tail down one slot before the push lands.
  assign push_idx = pop_i ? cnt_q - CW'(1) : cnt_q;

  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      slots_d = '0;
      cnt_d   = '0;
    end else begin
      if (pop_i) begin
        for (int i = 0; i < DEPTH - 1; i++) slots_d[i] = slots_q[i+1];
        slots_d[DEPTH-1] = '0;
      end
      if (push_i) begin
        for (int i = 0; i < DEPTH; i++)
          if (CW'(i) == push_idx) slots_d[i] = push_data_i;
      end
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q <= '0;
      cnt_q   <= '0;
    end else begin
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign slots_o = slots_q;

endmodule

// File: rtl/piece_sequencer.sv
// Owns the falling piece and the preview queue; refills from the 7-bag and
// serves lock-spawn and hold requests.
module piece_sequencer
  import DisplayPkg::*;
#(
  parameter int PREVIEW_DEPTH = PREVIEW_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  piece_sequencer_if.slave sq
);

  localparam int TW = $bits(tile_type_t);
  localparam int CW = $clog2(PREVIEW_DEPTH + 1);

  seq_state_t state_q, state_d;
  pend_t      pend_q, pend_d;
  tile_type_t falling_q, falling_d;
  logic       fvalid_q, fvalid_d;
  logic       newt_q, newt_d;
  logic       hdone_q, hdone_d;

  logic                       push, pop, flush, bag_ready;
  logic [CW-1:0]              count;
  logic [PREVIEW_DEPTH*TW-1:0] slots;
  tile_type_t                 head;

  // game_start blocks the bag so the flush cannot race a push.
  assign bag_ready = (state_q != IDLE) && (count < CW'(PREVIEW_DEPTH)) && !sq.game_start;
  assign push      = sq.bag_valid && bag_ready;
  assign head      = tile_type_t'(slots[TW-1:0]);

  piece_queue #(.DEPTH(PREVIEW_DEPTH), .W(TW)) u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (sq.bag_type),
    .pop_i       (pop),
    .count_o     (count),
    .slots_o     (slots)
  );

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    falling_d = falling_q;
    fvalid_d  = fvalid_q;
    newt_d    = 1'b0;
    hdone_d   = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    if (sq.game_start) begin
      flush     = 1'b1;
      falling_d = BLANK;
      fvalid_d  = 1'b0;
      state_d   = FILL;
    end else begin
      unique case (state_q)
        IDLE: ;
        FILL: if (count == CW'(PREVIEW_DEPTH)) begin
          pop       = 1'b1;
          falling_d = head;
          fvalid_d  = 1'b1;
          newt_d    = 1'b1;
          state_d   = READY;
        end
        READY: begin
          // spawn_req outranks hold_req; a coincident hold is dropped.
          if (sq.spawn_req) begin
            if (count != '0) begin
              pop       = 1'b1;
              falling_d = head;
              newt_d    = 1'b1;
            end else begin
              fvalid_d = 1'b0;
              pend_d   = PEND_SPAWN;
              state_d  = STALL;
            end
          end else if (sq.hold_req) begin
            if (sq.hold_swap) begin
              falling_d = sq.hold_type;
              hdone_d   = 1'b1;
            end else if (count != '0) begin
              pop       = 1'b1;
              falling_d = head;
              hdone_d   = 1'b1;
            end else begin
              fvalid_d = 1'b0;
              pend_d   = PEND_HOLD;
              state_d  = STALL;
            end
          end
        end
        STALL: if (count != '0) begin
          pop       = 1'b1;
          falling_d = head;
          fvalid_d  = 1'b1;
          newt_d    = (pend_q == PEND_SPAWN);
          hdone_d   = (pend_q == PEND_HOLD);
          state_d   = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= PEND_SPAWN;
      falling_q <= BLANK;
      fvalid_q  <= 1'b0;
      newt_q    <= 1'b0;
      hdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      falling_q <= falling_d;
      fvalid_q  <= fvalid_d;
      newt_q    <= newt_d;
      hdone_q   <= hdone_d;
    end
  end

  assign sq.bag_ready     = bag_ready;
  assign sq.falling_type  = falling_q;
  assign sq.falling_valid = fvalid_q;
  assign sq.new_tetromino = newt_q;
  assign sq.hold_done     = hdone_q;

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_prev
    assign sq.preview[g] = tile_type_t'(slots[g*TW +: TW]);
  end

endmodule
